// File: rtl/coffee_dispenser_ctrl_if.sv
// Front-panel bundle between the coin/selection panel and the dispenser controller.
// master = panel side (drives coins/buttons), slave = controller side.
interface coffee_dispenser_ctrl_if #(
  parameter int SEL_W    = 3,
  parameter int CREDIT_W = 8
);
  logic                coin_100;
  logic                coin_500;
  logic [SEL_W-1:0]    coffee_type;
  logic                confirm;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] change;
  logic                water;
  logic                coffee;
  logic                milk;
  logic                chocolate;
  logic                sugar;
  logic                busy;
  logic                finished;
  logic                denied;

  modport master (
    output coin_100, coin_500, coffee_type, confirm, cancel,
    input  credit, change, water, coffee, milk, chocolate, sugar, busy, finished, denied
  );

  modport slave (
    input  coin_100, coin_500, coffee_type, confirm, cancel,
    output credit, change, water, coffee, milk, chocolate, sugar, busy, finished, denied
  );
endinterface

// File: rtl/coffee_dispenser_ctrl.sv
// Coin-operated coffee controller: credit accumulation, price check, timed valve
// recipe sequencing and change return. All outputs are registered.
module coffee_dispenser_ctrl #(
  parameter int                                 NUM_PRODUCTS = 5,
  parameter int                                 SEL_W        = 3,
  parameter int                                 CREDIT_W     = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]   PRICES       = {CREDIT_W'(8), CREDIT_W'(7),
                                                                CREDIT_W'(6), CREDIT_W'(5),
                                                                CREDIT_W'(3)},
  parameter logic [NUM_PRODUCTS*5-1:0]          RECIPES      = {5'h1F, 5'h0D, 5'h07, 5'h13, 5'h03},
  parameter int                                 STEP_CYCLES  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  coffee_dispenser_ctrl_if.slave bus
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int EXT_W = CREDIT_W + 3;

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [4:0]          valve_q, valve_d;
  logic [4:0]          rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                denied_q, denied_d;
  logic [3:0]          hist_q;

  logic [3:0]          raw, evt;
  logic [2:0]          gain;
  logic                coin_ev, sel_ok, do_cancel, do_confirm, accept;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] price;
  logic [4:0]          recipe;

  function automatic logic [CREDIT_W-1:0] sat(input logic [EXT_W-1:0] v);
    return (|v[EXT_W-1:CREDIT_W]) ? {CREDIT_W{1'b1}} : v[CREDIT_W-1:0];
  endfunction

  function automatic logic [4:0] lowbit(input logic [4:0] m);
    return m & (~m + 5'd1);
  endfunction

  // {cancel, confirm, coin_500, coin_100}
  assign raw     = {bus.cancel, bus.confirm, bus.coin_500, bus.coin_100};
  assign evt     = raw & ~hist_q;
  assign gain    = (evt[0] ? 3'd1 : 3'd0) + (evt[1] ? 3'd5 : 3'd0);
  assign coin_ev = evt[0] | evt[1];

  assign sel_ok     = int'(bus.coffee_type) < NUM_PRODUCTS;
  assign sel_idx    = sel_ok ? bus.coffee_type : '0;
  assign price      = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
  assign recipe     = RECIPES[sel_idx*5 +: 5];
  assign do_cancel  = evt[3] && (credit_q != '0);
  // a cancel edge always shadows a confirm on the same cycle, even with no credit
  assign do_confirm = evt[2] && !evt[3];
  assign accept     = do_confirm && sel_ok && (credit_q >= price);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    valve_d  = valve_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    denied_d = 1'b0;
    case (state_q)
      IDLE: begin
        valve_d = '0;
        if (do_cancel) begin
          change_d = sat(EXT_W'(credit_q) + EXT_W'(gain));
          credit_d = '0;
        end else if (accept) begin
          change_d = sat(EXT_W'(credit_q) - EXT_W'(price) + EXT_W'(gain));
          credit_d = '0;
          if (recipe == '0) begin
            state_d = DONE;
          end else begin
            state_d = DISPENSE;
            valve_d = lowbit(recipe);
            rem_d   = recipe & ~lowbit(recipe);
            cnt_d   = CNT_W'(STEP_CYCLES - 1);
          end
        end else begin
          denied_d = do_confirm;
          if (coin_ev) begin
            credit_d = sat(EXT_W'(credit_q) + EXT_W'(gain));
            // zero credit means this coin opens a new transaction
            if (credit_q == '0) change_d = '0;
          end
        end
      end
      DISPENSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rem_q != '0) begin
          valve_d = lowbit(rem_q);
          rem_d   = rem_q & ~lowbit(rem_q);
          cnt_d   = CNT_W'(STEP_CYCLES - 1);
        end else begin
          valve_d = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    finished_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      change_q   <= '0;
      valve_q    <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      denied_q   <= 1'b0;
      hist_q     <= '1;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      valve_q    <= valve_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      denied_q   <= denied_d;
      hist_q     <= raw;
    end
  end

  assign bus.credit    = credit_q;
  assign bus.change    = change_q;
  assign bus.water     = valve_q[0];
  assign bus.coffee    = valve_q[1];
  assign bus.milk      = valve_q[2];
  assign bus.chocolate = valve_q[3];
  assign bus.sugar     = valve_q[4];
  assign bus.busy      = busy_q;
  assign bus.finished  = finished_q;
  assign bus.denied    = denied_q;

endmodule

// File: tb/tb_coffee_dispenser_ctrl.sv
// Directed bench for coffee_dispenser_ctrl: default build plus a CREDIT_W=3 build for saturation.
module tb_coffee_dispenser_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  coffee_dispenser_ctrl_if #(.SEL_W(3), .CREDIT_W(8)) b ();
  coffee_dispenser_ctrl_if #(.SEL_W(3), .CREDIT_W(3)) bs ();

  coffee_dispenser_ctrl u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (b.slave)
  );

  coffee_dispenser_ctrl #(
    .CREDIT_W (3),
    .PRICES   ({3'd7, 3'd7, 3'd6, 3'd5, 3'd3})
  ) u_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bs.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse100();
    b.coin_100 = 1'b1; step();
    b.coin_100 = 1'b0; step();
  endtask

  task automatic pulse500();
    b.coin_500 = 1'b1; step();
    b.coin_500 = 1'b0; step();
  endtask

  // Expected {finished,busy,sugar,chocolate,milk,coffee,water} k cycles after the accepting edge.
  function automatic logic [6:0] exp_out(input logic [4:0] mask, input int k);
    int ord[5];
    int n = 0;
    for (int i = 0; i < 5; i++) if (mask[i]) begin ord[n] = i; n++; end
    if (k < 4 * n) return 7'b0100000 | (7'(1) << ord[k / 4]);
    if (k == 4 * n) return 7'b1100000;
    return 7'b0;
  endfunction

  function automatic logic [6:0] obs();
    return {b.finished, b.busy, b.sugar, b.chocolate, b.milk, b.coffee, b.water};
  endfunction

  task automatic test_reset();
    b.coin_100 = 0; b.coin_500 = 0; b.confirm = 0; b.cancel = 0; b.coffee_type = 0;
    bs.coin_100 = 0; bs.coin_500 = 0; bs.confirm = 0; bs.cancel = 0; bs.coffee_type = 0;
    reset = 1'b0;
    step(); step();
    checks++;
    if ({b.credit, b.change, obs(), b.denied} !== 24'd0) begin
      failures++;
      $display("FAIL reset_state got credit=%0d change=%0d outs=%b denied=%b want all 0",
               b.credit, b.change, obs(), b.denied);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [6:0] e;
    repeat (4) pulse100();
    checks++;
    if (b.credit !== 8'd4) begin failures++; $display("FAIL basic_credit got %0d want 4", b.credit); end
    b.coffee_type = 3'd0; b.confirm = 1'b1; step();
    checks++;
    if (b.credit !== 8'd0 || b.change !== 8'd1) begin
      failures++; $display("FAIL basic_change got credit=%0d change=%0d want 0/1", b.credit, b.change);
    end
    for (int k = 0; k <= 9; k++) begin
      e = exp_out(5'h03, k);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL basic_seq k=%0d got %b want %b", k, obs(), e); end
      b.confirm = 1'b0;
      step();
    end
  endtask

  task automatic test_deny();
    logic [6:0] e;
    repeat (5) pulse100();
    checks++;
    if (b.credit !== 8'd5 || b.change !== 8'd0) begin
      failures++; $display("FAIL deny_credit got credit=%0d change=%0d want 5/0", b.credit, b.change);
    end
    b.coffee_type = 3'd2; b.confirm = 1'b1; step();
    checks++;
    if (b.denied !== 1'b1 || b.credit !== 8'd5 || b.busy !== 1'b0) begin
      failures++; $display("FAIL deny_price got denied=%b credit=%0d busy=%b want 1/5/0", b.denied, b.credit, b.busy);
    end
    b.confirm = 1'b0; step();
    checks++;
    if (b.denied !== 1'b0) begin failures++; $display("FAIL deny_pulse got %b want 0", b.denied); end
    b.coffee_type = 3'd6; b.confirm = 1'b1; step();
    checks++;
    if (b.denied !== 1'b1 || b.credit !== 8'd5) begin
      failures++; $display("FAIL deny_invalid got denied=%b credit=%0d want 1/5", b.denied, b.credit);
    end
    b.confirm = 1'b0; step();
    pulse100();
    b.coffee_type = 3'd2; b.confirm = 1'b1; step();
    checks++;
    if (b.credit !== 8'd0 || b.change !== 8'd0 || b.denied !== 1'b0) begin
      failures++; $display("FAIL deny_accept got credit=%0d change=%0d denied=%b want 0/0/0", b.credit, b.change, b.denied);
    end
    for (int k = 0; k <= 13; k++) begin
      e = exp_out(5'h07, k);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL deny_seq k=%0d got %b want %b", k, obs(), e); end
      b.confirm = 1'b0;
      step();
    end
  endtask

  task automatic test_full_recipe();
    logic [6:0] e;
    pulse500(); pulse500();
    checks++;
    if (b.credit !== 8'd10) begin failures++; $display("FAIL full_credit got %0d want 10", b.credit); end
    b.coffee_type = 3'd4; b.confirm = 1'b1; step();
    checks++;
    if (b.change !== 8'd2 || b.credit !== 8'd0) begin
      failures++; $display("FAIL full_change got change=%0d credit=%0d want 2/0", b.change, b.credit);
    end
    for (int k = 0; k <= 20; k++) begin
      e = exp_out(5'h1F, k);
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL full_seq k=%0d got %b want %b", k, obs(), e); end
      b.confirm = 1'b0;
      b.coin_100 = (k < 18) && (k % 2 == 0);
      b.coin_500 = (k < 18) && (k % 4 == 1);
      step();
    end
    step();
    checks++;
    if (b.credit !== 8'd0 || b.busy !== 1'b0) begin
      failures++; $display("FAIL full_ignored got credit=%0d busy=%b want 0/0", b.credit, b.busy);
    end
  endtask

  task automatic test_cancel_priority();
    pulse500(); pulse100(); pulse100();
    checks++;
    if (b.credit !== 8'd7 || b.change !== 8'd0) begin
      failures++; $display("FAIL cancel_credit got credit=%0d change=%0d want 7/0", b.credit, b.change);
    end
    b.coffee_type = 3'd0; b.confirm = 1'b1; b.cancel = 1'b1; step();
    checks++;
    if (b.credit !== 8'd0 || b.change !== 8'd7 || b.denied !== 1'b0 || obs() !== 7'd0) begin
      failures++; $display("FAIL cancel_prio got credit=%0d change=%0d denied=%b outs=%b want 0/7/0/0",
                           b.credit, b.change, b.denied, obs());
    end
    b.confirm = 1'b0; b.cancel = 1'b0; step();
    checks++;
    if (b.busy !== 1'b0 || b.change !== 8'd7) begin
      failures++; $display("FAIL cancel_idle got busy=%b change=%0d want 0/7", b.busy, b.change);
    end
  endtask

  task automatic test_saturation();
    bs.coin_100 = 1'b1; bs.coin_500 = 1'b1; step();
    checks++;
    if (bs.credit !== 3'd6) begin failures++; $display("FAIL sat_both got %0d want 6", bs.credit); end
    bs.coin_100 = 1'b0; bs.coin_500 = 1'b0; step();
    bs.coin_500 = 1'b1; step();
    checks++;
    if (bs.credit !== 3'd7) begin failures++; $display("FAIL sat_clamp got %0d want 7", bs.credit); end
    bs.coin_500 = 1'b0; step();
    bs.coin_100 = 1'b1; step();
    checks++;
    if (bs.credit !== 3'd7) begin failures++; $display("FAIL sat_hold got %0d want 7", bs.credit); end
    bs.coin_100 = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    pulse500();
    checks++;
    if (b.credit !== 8'd5 || b.change !== 8'd0) begin
      failures++; $display("FAIL rst_credit got credit=%0d change=%0d want 5/0", b.credit, b.change);
    end
    b.coffee_type = 3'd1; b.confirm = 1'b1; step();
    b.confirm = 1'b0;
    repeat (5) step();
    checks++;
    if (obs() !== 7'b0100010) begin failures++; $display("FAIL rst_second_valve got %b want 0100010", obs()); end
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'd0 || b.credit !== 8'd0) begin
      failures++; $display("FAIL rst_async got outs=%b credit=%0d want 0/0", obs(), b.credit);
    end
    b.coin_100 = 1'b1;
    step();
    reset = 1'b1;
    step(); step();
    checks++;
    if (b.credit !== 8'd0 || b.busy !== 1'b0) begin
      failures++; $display("FAIL rst_held_coin got credit=%0d busy=%b want 0/0", b.credit, b.busy);
    end
    b.coin_100 = 1'b0; step();
    b.coin_100 = 1'b1; step();
    checks++;
    if (b.credit !== 8'd1) begin failures++; $display("FAIL rst_coin_after got %0d want 1", b.credit); end
    b.coin_100 = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deny();
    test_full_recipe();
    test_cancel_priority();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coffee_dispenser_ctrl.md
Name: coffee_dispenser_ctrl

Overview:
Parametrised coffee vending controller for the lab FPGA design. It accumulates coin credit and checks the price of the selected product. It then runs that product's ingredient recipe as a timed valve sequence and returns change. Credit and change are binary outputs; 7-segment decoding sits in a separate display block.

Parameters:
NUM_PRODUCTS, 5, number of valid selections (codes 0..NUM_PRODUCTS-1).
SEL_W, 3, width of coffee_type; 2**SEL_W >= NUM_PRODUCTS.
CREDIT_W, 8, width of credit/change in units of 100; max credit = 2**CREDIT_W-1.
PRICES, {8,7,6,5,3}, packed NUM_PRODUCTS*CREDIT_W prices in units of 100; product i is at slice [i*CREDIT_W +: CREDIT_W], so product 0 = 3.
RECIPES, {5'h1F,5'h0D,5'h07,5'h13,5'h03}, packed NUM_PRODUCTS*5 ingredient masks; product i at slice [i*5 +: 5], so product 0 = 5'h03. Bit 0 water, 1 coffee, 2 milk, 3 chocolate, 4 sugar.
STEP_CYCLES, 4, cycles each enabled ingredient valve stays open (>=1).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
coin_100  in  1  level from coin slot; each rising edge = +1 credit unit.
coin_500  in  1  each rising edge = +5 credit units.
coffee_type  in  SEL_W  product selection, sampled on the confirm edge.
confirm  in  1  rising edge requests purchase.
cancel  in  1  rising edge returns all credit as change.
credit  out  CREDIT_W  current accumulated credit.
change  out  CREDIT_W  last change returned; held until cleared.
water, coffee, milk, chocolate, sugar  out  1 each  ingredient valves; at most one high at a time.
busy  out  1  high while dispensing, including the finished cycle.
finished  out  1  one-cycle pulse at the end of dispensing.
denied  out  1  one-cycle pulse when a confirm is rejected.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, credit/change 0. The edge-detect history registers reset to 1, so an input held high across reset release is not counted. Reset mid-dispense closes the valves immediately, and credit is lost.
- Edge detect: event = input high at the clock edge while its previous sample was low. All inputs are synchronous to clock.
- States: IDLE, DISPENSE, DONE. Register every output.
- IDLE, coins: the credit gain is 1 per coin_100 edge plus 5 per coin_500 edge. Simultaneous edges add 6. The sum saturates at 2**CREDIT_W-1 and never wraps. The first accepted coin of a transaction clears change to 0.
- IDLE, cancel edge: change<=credit, credit<=0. Cancel has priority over confirm in the same cycle. Cancel with credit 0 does nothing.
- IDLE, confirm edge: if coffee_type>=NUM_PRODUCTS or credit<price, then denied=1 for one cycle and credit is kept. Otherwise change<=credit-price, credit<=0, and go to DISPENSE. The price comparison uses the registered credit. A coin edge in the same cycle as an accepted confirm is added to change, saturating.
- DISPENSE: step through the mask bits in order 0..4, skipping zero bits. Each enabled valve is high for exactly STEP_CYCLES consecutive cycles. The first valve is high in the cycle after the accepting edge. The next valve follows with no gap. After the last valve go to DONE. An empty mask goes straight to DONE.
- DONE: finished=1 and busy=1 for one cycle, then IDLE.
- Coin, confirm and cancel edges outside IDLE are ignored and do not add credit.
- busy=1 from the first DISPENSE cycle through the DONE cycle.

Test Plan:
- Basic purchase: four coin_100 edges (credit=4), coffee_type=0, confirm -> credit=0, change=1, water high 4 cycles, then coffee 4 cycles, finished pulse, busy for 9 cycles.
- Insufficient or invalid: credit=5, coffee_type=2 (price 6) confirm -> denied pulse, credit stays 5. coffee_type=6 confirm -> denied pulse. Then one coin_100 and confirm -> water, coffee, milk sequence (12 cycles), change=0.
- Full recipe and ignored input: credit=10, coffee_type=4 -> five valves of 4 cycles each, in order water..sugar, change=2. Coin edges during dispense leave credit at 0.
- Cancel priority: credit=7, confirm and cancel on the same edge -> change=7, credit=0, no dispense, no denied.
- Saturation and simultaneous coins, with CREDIT_W=3: coin_100 and coin_500 on the same edge -> credit=6. One more coin_500 -> credit=7, not 11 or 3.
- Reset cases: reset=0 during the second valve -> all valves 0 immediately, credit=0. coin_100 held high across reset release -> credit stays 0.
